motion_centroid_tracker: RTL and testbench

//  Parametrised per-frame motion centroid tracker. Consumes the binary motion stream (one bit per pixel,

---
 rtl/motion_centroid_tracker_pkg.sv | 27 ++
 rtl/motion_centroid_tracker_if.sv | 19 +
 rtl/motion_centroid_tracker_seq_divider.sv | 62 ++++++
 rtl/motion_centroid_tracker.sv | 270 +++++++++++++++++++++++++++
 tb/tb_motion_centroid_tracker.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motion_centroid_tracker_pkg.sv
// Shared definitions for the motion centroid tracker: default geometry,
// width helpers and the controller state encoding.
package motion_centroid_tracker_pkg;

  localparam int DEF_X_WIDTH = 9;
  localparam int DEF_Y_WIDTH = 8;
  localparam int DEF_IMAGE_W = 320;
  localparam int DEF_IMAGE_H = 240;

  // Width needed to count every pixel of a w x h image, including the full count.
  function automatic int cnt_width_f(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DIV_X   = 3'd1,
    ST_DIV_Y   = 3'd2,
    ST_SMOOTH  = 3'd3,
    ST_PUBLISH = 3'd4
  } state_e;

endpackage

// File: rtl/motion_centroid_tracker_if.sv
// Binary motion pixel stream from the difference/smoothing stage, with the
// frame-closing pulse. The producer uses the master view, the tracker the slave view.
interface motion_centroid_tracker_if
  import motion_centroid_tracker_pkg::*;
#(
  parameter int X_WIDTH = DEF_X_WIDTH,
  parameter int Y_WIDTH = DEF_Y_WIDTH
);

  logic               pix_valid;
  logic [X_WIDTH-1:0] pix_x;
  logic [Y_WIDTH-1:0] pix_y;
  logic               pix_motion;
  logic               frame_end;

  modport master (output pix_valid, pix_x, pix_y, pix_motion, frame_end);
  modport slave  (input  pix_valid, pix_x, pix_y, pix_motion, frame_end);

endinterface

// File: rtl/motion_centroid_tracker_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The first step runs
// in the start cycle itself, so a WIDTH-bit divide occupies exactly WIDTH
// cycles; done flags the cycle of the final step and the quotient is valid
// from the following cycle until the next start.
module seq_divider #(
  parameter int WIDTH   = 26,
  parameter int Q_WIDTH = 9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [Q_WIDTH-1:0] quotient,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, rem_in, quo_in;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   trial;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    rem_in = start ? '0 : rem_q;
    quo_in = start ? dividend : quo_q;
    trial  = {rem_in, quo_in[WIDTH-1]};
    if (start || (cnt_q != '0)) begin
      if (trial >= {1'b0, divisor}) begin
        rem_d = WIDTH'(trial - {1'b0, divisor});
        quo_d = {quo_in[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_in[WIDTH-2:0], 1'b0};
      end
      cnt_d = start ? CW'(WIDTH - 1) : cnt_q - CW'(1);
    end
  end

  // Remainder, quotient shifter and remaining-step counter.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

  assign done     = !start && (cnt_q == CW'(1));
  assign quotient = quo_q[Q_WIDTH-1:0];

endmodule

// File: rtl/motion_centroid_tracker.sv
// Per-frame motion centroid tracker: accumulates motion pixel count and x/y
// sums, divides sequentially at frame end (accumulation of the next frame
// continues meanwhile), IIR-smooths the centroid and logs it in a circular
// history. Optional bounding box outputs: MOTION_CENTROID_BBOX_EN.
module motion_centroid_tracker
  import motion_centroid_tracker_pkg::*;
#(
  parameter  int X_WIDTH         = DEF_X_WIDTH,
  parameter  int Y_WIDTH         = DEF_Y_WIDTH,
  parameter  int IMAGE_W         = DEF_IMAGE_W,
  parameter  int IMAGE_H         = DEF_IMAGE_H,
  parameter  int COUNT_THRESHOLD = 400,
  parameter  int ALPHA_NUM       = 6,
  parameter  int ALPHA_SHIFT     = 4,
  parameter  int HIST_DEPTH      = 10,
  localparam int CNT_WIDTH       = cnt_width_f(IMAGE_W, IMAGE_H),
  localparam int HIDX_W          = $clog2(HIST_DEPTH),
  localparam int HCNT_W          = $clog2(HIST_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  motion_centroid_tracker_if.slave pix,
  output logic                 centroid_valid,
  output logic                 detected,
  output logic [X_WIDTH-1:0]   centroid_x,
  output logic [Y_WIDTH-1:0]   centroid_y,
  output logic [CNT_WIDTH-1:0] motion_count,
  output logic                 busy,
  output logic                 overrun,
  input  logic [HIDX_W-1:0]    hist_rd_idx,
  output logic [X_WIDTH-1:0]   hist_rd_x,
  output logic [Y_WIDTH-1:0]   hist_rd_y,
  output logic [HCNT_W-1:0]    hist_count
`ifdef MOTION_CENTROID_BBOX_EN
  ,
  output logic [X_WIDTH-1:0]   bbox_x_min,
  output logic [X_WIDTH-1:0]   bbox_x_max,
  output logic [Y_WIDTH-1:0]   bbox_y_min,
  output logic [Y_WIDTH-1:0]   bbox_y_max
`endif
);

  localparam int SUM_WIDTH = CNT_WIDTH + max_f(X_WIDTH, Y_WIDTH);
  localparam int Q_WIDTH   = max_f(X_WIDTH, Y_WIDTH);
  localparam int MIX_XW    = X_WIDTH + ALPHA_SHIFT + 1;
  localparam int MIX_YW    = Y_WIDTH + ALPHA_SHIFT + 1;
  localparam int KEEP      = (2 ** ALPHA_SHIFT) - ALPHA_NUM;

  state_e               state_q, state_d;
  logic                 div_start_q, div_start_d, div_done;
  logic [Q_WIDTH-1:0]   div_quo;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_acc, snap_cnt_q, cnt_pub_q;
  logic [SUM_WIDTH-1:0] sx_q, sy_q, sx_acc, sy_acc, snap_sx_q, snap_sy_q;
  logic                 hit, fe_idle, above_thr, snap_det, publish, det_q;
  logic [X_WIDTH-1:0]   raw_x_q, avg_x_q;
  logic [Y_WIDTH-1:0]   avg_y_q, raw_y;
  logic                 seeded_q;
  logic [MIX_XW-1:0]    mix_x;
  logic [MIX_YW-1:0]    mix_y;
  logic [X_WIDTH-1:0]   hist_x_q [HIST_DEPTH];
  logic [Y_WIDTH-1:0]   hist_y_q [HIST_DEPTH];
  logic [HIDX_W-1:0]    wr_ptr_q;
  logic [HCNT_W-1:0]    hist_cnt_q;

  assign hit = pix.pix_valid && pix.pix_motion &&
               (32'(pix.pix_x) < IMAGE_W) && (32'(pix.pix_y) < IMAGE_H);
  assign cnt_acc   = cnt_q + CNT_WIDTH'(hit);
  assign sx_acc    = sx_q + (hit ? SUM_WIDTH'(pix.pix_x) : '0);
  assign sy_acc    = sy_q + (hit ? SUM_WIDTH'(pix.pix_y) : '0);
  assign above_thr = 32'(cnt_acc) >= COUNT_THRESHOLD;
  assign fe_idle   = pix.frame_end && (state_q == ST_IDLE);
  assign snap_det  = 32'(snap_cnt_q) >= COUNT_THRESHOLD;
  assign publish   = (state_q == ST_PUBLISH);

  // Running accumulators; a frame_end (accepted or dropped) restarts them.
  always_ff @(posedge clock) begin
    if (reset || pix.frame_end) begin
      cnt_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
    end else begin
      cnt_q <= cnt_acc;
      sx_q  <= sx_acc;
      sy_q  <= sy_acc;
    end
  end

  // Frame snapshot taken when the controller accepts a frame, same-cycle pixel included.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_cnt_q <= '0;
      snap_sx_q  <= '0;
      snap_sy_q  <= '0;
    end else if (fe_idle) begin
      snap_cnt_q <= cnt_acc;
      snap_sx_q  <= sx_acc;
      snap_sy_q  <= sy_acc;
    end
  end

  // Controller state register and divider start strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_start_q <= div_start_d;
    end
  end

  // Controller next state: small frames skip straight to publish.
  always_comb begin
    state_d     = state_q;
    div_start_d = 1'b0;
    case (state_q)
      ST_IDLE: if (pix.frame_end) begin
        state_d     = above_thr ? ST_DIV_X : ST_PUBLISH;
        div_start_d = above_thr;
      end
      ST_DIV_X: if (div_done) begin
        state_d     = ST_DIV_Y;
        div_start_d = 1'b1;
      end
      ST_DIV_Y:   if (div_done) state_d = ST_SMOOTH;
      ST_SMOOTH:  state_d = ST_PUBLISH;
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  seq_divider #(.WIDTH(SUM_WIDTH), .Q_WIDTH(Q_WIDTH)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start_q),
    .dividend ((state_q == ST_DIV_Y) ? snap_sy_q : snap_sx_q),
    .divisor  (SUM_WIDTH'(snap_cnt_q)),
    .quotient (div_quo),
    .done     (div_done)
  );

  assign raw_y = div_quo[Y_WIDTH-1:0];
  assign mix_x = MIX_XW'(avg_x_q) * MIX_XW'(KEEP) + MIX_XW'(raw_x_q) * MIX_XW'(ALPHA_NUM);
  assign mix_y = MIX_YW'(avg_y_q) * MIX_YW'(KEEP) + MIX_YW'(raw_y) * MIX_YW'(ALPHA_NUM);

  // Keep the x quotient while the divider is reused for y, then blend into the average.
  always_ff @(posedge clock) begin
    if (reset) begin
      raw_x_q  <= '0;
      avg_x_q  <= '0;
      avg_y_q  <= '0;
      seeded_q <= 1'b0;
    end else begin
      if ((state_q == ST_DIV_Y) && div_start_q) raw_x_q <= div_quo[X_WIDTH-1:0];
      if (state_q == ST_SMOOTH) begin
        avg_x_q  <= seeded_q ? X_WIDTH'(mix_x >> ALPHA_SHIFT) : raw_x_q;
        avg_y_q  <= seeded_q ? Y_WIDTH'(mix_y >> ALPHA_SHIFT) : raw_y;
        seeded_q <= 1'b1;
      end
    end
  end

  // Published per-frame status, held until the next publish.
  always_ff @(posedge clock) begin
    if (reset) begin
      det_q     <= 1'b0;
      cnt_pub_q <= '0;
    end else if (publish) begin
      det_q     <= snap_det;
      cnt_pub_q <= snap_cnt_q;
    end
  end

  assign centroid_valid = publish;
  assign detected       = publish ? snap_det : det_q;
  assign motion_count   = publish ? snap_cnt_q : cnt_pub_q;
  assign centroid_x     = avg_x_q;
  assign centroid_y     = avg_y_q;
  assign busy           = (state_q != ST_IDLE);
  assign overrun        = !reset && pix.frame_end && busy;

  // History storage, written at the end of a detected publish.
  always_ff @(posedge clock) begin
    // NOTE: the history array has no reset; the entry count alone decides what is readable.
    if (publish && snap_det) begin
      hist_x_q[wr_ptr_q] <= avg_x_q;
      hist_y_q[wr_ptr_q] <= avg_y_q;
    end
  end

  // History write pointer and saturating entry count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      hist_cnt_q <= '0;
    end else if (publish && snap_det) begin
      wr_ptr_q <= (wr_ptr_q == HIDX_W'(HIST_DEPTH - 1)) ? '0 : wr_ptr_q + HIDX_W'(1);
      if (hist_cnt_q != HCNT_W'(HIST_DEPTH)) hist_cnt_q <= hist_cnt_q + HCNT_W'(1);
    end
  end

  // Newest-first history read; indices past the valid entries read zero.
  always_comb begin
    int pos;
    hist_rd_x = '0;
    hist_rd_y = '0;
    pos = int'(wr_ptr_q) + HIST_DEPTH - 1 - int'(hist_rd_idx);
    if (pos >= HIST_DEPTH) pos = pos - HIST_DEPTH;
    if (32'(hist_rd_idx) < 32'(hist_cnt_q)) begin
      hist_rd_x = hist_x_q[HIDX_W'(pos)];
      hist_rd_y = hist_y_q[HIDX_W'(pos)];
    end
  end

  assign hist_count = hist_cnt_q;

`ifdef MOTION_CENTROID_BBOX_EN
  logic [X_WIDTH-1:0] bx_min_q, bx_max_q, sbx_min_q, sbx_max_q, pbx_min_q, pbx_max_q;
  logic [Y_WIDTH-1:0] by_min_q, by_max_q, sby_min_q, sby_max_q, pby_min_q, pby_max_q;
  logic [X_WIDTH-1:0] bx_min_acc, bx_max_acc;
  logic [Y_WIDTH-1:0] by_min_acc, by_max_acc;

  assign bx_min_acc = (hit && (pix.pix_x < bx_min_q)) ? pix.pix_x : bx_min_q;
  assign bx_max_acc = (hit && (pix.pix_x > bx_max_q)) ? pix.pix_x : bx_max_q;
  assign by_min_acc = (hit && (pix.pix_y < by_min_q)) ? pix.pix_y : by_min_q;
  assign by_max_acc = (hit && (pix.pix_y > by_max_q)) ? pix.pix_y : by_max_q;

  // Running extent of counted pixels; minimum restarts at all-ones.
  always_ff @(posedge clock) begin
    if (reset || pix.frame_end) begin
      bx_min_q <= '1;
      bx_max_q <= '0;
      by_min_q <= '1;
      by_max_q <= '0;
    end else begin
      bx_min_q <= bx_min_acc;
      bx_max_q <= bx_max_acc;
      by_min_q <= by_min_acc;
      by_max_q <= by_max_acc;
    end
  end

  // Extent snapshot at frame acceptance and published copy after a detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      {sbx_min_q, sbx_max_q, sby_min_q, sby_max_q} <= '0;
      {pbx_min_q, pbx_max_q, pby_min_q, pby_max_q} <= '0;
    end else begin
      if (fe_idle) begin
        sbx_min_q <= bx_min_acc;
        sbx_max_q <= bx_max_acc;
        sby_min_q <= by_min_acc;
        sby_max_q <= by_max_acc;
      end
      if (publish && snap_det) begin
        pbx_min_q <= sbx_min_q;
        pbx_max_q <= sbx_max_q;
        pby_min_q <= sby_min_q;
        pby_max_q <= sby_max_q;
      end
    end
  end

  assign bbox_x_min = (publish && snap_det) ? sbx_min_q : pbx_min_q;
  assign bbox_x_max = (publish && snap_det) ? sbx_max_q : pbx_max_q;
  assign bbox_y_min = (publish && snap_det) ? sby_min_q : pby_min_q;
  assign bbox_y_max = (publish && snap_det) ? sby_max_q : pby_max_q;
`endif

endmodule

// File: tb/tb_motion_centroid_tracker.sv
// Directed bench for motion_centroid_tracker at default parameters.
module tb_motion_centroid_tracker;

  localparam int XW  = 9;
  localparam int YW  = 8;
  localparam int CW  = 17;
  localparam int HIW = 4;
  localparam int HCW = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           centroid_valid, detected, busy, overrun;
  logic [XW-1:0]  centroid_x, hist_rd_x;
  logic [YW-1:0]  centroid_y, hist_rd_y;
  logic [CW-1:0]  motion_count;
  logic [HIW-1:0] hist_rd_idx;
  logic [HCW-1:0] hist_count;
`ifdef MOTION_CENTROID_BBOX_EN
  logic [XW-1:0]  bbox_x_min, bbox_x_max;
  logic [YW-1:0]  bbox_y_min, bbox_y_max;
`endif

  always #5 clock = ~clock;

  motion_centroid_tracker_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) pix_bus ();

  motion_centroid_tracker dut (
    .clock          (clock),
    .reset          (reset),
    .pix            (pix_bus),
    .centroid_valid (centroid_valid),
    .detected       (detected),
    .centroid_x     (centroid_x),
    .centroid_y     (centroid_y),
    .motion_count   (motion_count),
    .busy           (busy),
    .overrun        (overrun),
    .hist_rd_idx    (hist_rd_idx),
    .hist_rd_x      (hist_rd_x),
    .hist_rd_y      (hist_rd_y),
    .hist_count     (hist_count)
`ifdef MOTION_CENTROID_BBOX_EN
    ,
    .bbox_x_min     (bbox_x_min),
    .bbox_x_max     (bbox_x_max),
    .bbox_y_min     (bbox_y_min),
    .bbox_y_max     (bbox_y_max)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference smoothed centroid
  int  avg_x = 0, avg_y = 0;
  bit  seeded = 1'b0;
  int  res_x [12];
  int  res_y [12];

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_update(input int raw_x, input int raw_y);
    if (!seeded) begin
      avg_x  = raw_x;
      avg_y  = raw_y;
      seeded = 1'b1;
    end else begin
      avg_x = (avg_x * 10 + raw_x * 6) >> 4;
      avg_y = (avg_y * 10 + raw_y * 6) >> 4;
    end
  endtask

  task automatic clear_inputs();
    pix_bus.pix_valid  = 1'b0;
    pix_bus.pix_x      = '0;
    pix_bus.pix_y      = '0;
    pix_bus.pix_motion = 1'b0;
    pix_bus.frame_end  = 1'b0;
  endtask

  task automatic drive(input bit v, input int x, input int y, input bit m, input bit fe);
    @(negedge clock);
    pix_bus.pix_valid  = v;
    pix_bus.pix_x      = XW'(x);
    pix_bus.pix_y      = YW'(y);
    pix_bus.pix_motion = m;
    pix_bus.frame_end  = fe;
  endtask

  // n pixels of a 20-wide block; the last one carries frame_end.
  task automatic send_block(input int x0, input int y0, input int n);
    for (int p = 0; p < n; p++) drive(1'b1, x0 + p % 20, y0 + p / 20, 1'b1, p == n - 1);
  endtask

  // Cycles from the frame_end cycle to centroid_valid; -1 if it never comes.
  task automatic wait_publish(output int lat, output bit busy_first);
    lat = -1;
    busy_first = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      if (i == 1) begin
        clear_inputs();
        busy_first = busy;
      end
      if (centroid_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic read_hist(input int idx, output int x, output int y);
    hist_rd_idx = HIW'(idx);
    #1;
    x = int'(hist_rd_x);
    y = int'(hist_rd_y);
  endtask

  // Checks the publish cycle, then that the pulse lasts one cycle.
  task automatic check_publish(input string tag, input int lat, input int exp_lat, input bit exp_det,
                               input int ex, input int ey, input int exp_cnt);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_detected"}, detected, exp_det);
    check({tag, "_cx"}, centroid_x, ex);
    check({tag, "_cy"}, centroid_y, ey);
    check({tag, "_count"}, motion_count, exp_cnt);
    @(negedge clock);
    check({tag, "_valid_pulse"}, centroid_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, hx, hy, pulses;
    bit b1;

    clear_inputs();
    hist_rd_idx = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_valid", centroid_valid, 0);
    check("rst_detected", detected, 0);
    check("rst_cx", centroid_x, 0);
    check("rst_cy", centroid_y, 0);
    check("rst_count", motion_count, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_hist_count", hist_count, 0);
    read_hist(0, hx, hy);
    check("rst_hist0_x", hx, 0);
    reset = 1'b0;

    // 1: ignored pixels, then 20x20 block at (100..119, 50..69)
    drive(1'b1, 320, 10, 1'b1, 1'b0);
    drive(1'b1, 10, 240, 1'b1, 1'b0);
    drive(1'b0, 10, 10, 1'b1, 1'b0);
    drive(1'b1, 10, 10, 1'b0, 1'b0);
    drive(1'b1, 511, 255, 1'b1, 1'b0);
    send_block(100, 50, 400);
    wait_publish(lat, b1);
    check("t1_busy", b1, 1);
`ifdef MOTION_CENTROID_BBOX_EN
    check("t1_bbox_xmin", bbox_x_min, 100);
    check("t1_bbox_xmax", bbox_x_max, 119);
    check("t1_bbox_ymin", bbox_y_min, 50);
    check("t1_bbox_ymax", bbox_y_max, 69);
`endif
    check_publish("t1", lat, 54, 1'b1, 109, 59, 400);
    check("t1_hist_count", hist_count, 1);
    read_hist(0, hx, hy);
    check("t1_hist0_x", hx, 109);
    check("t1_hist0_y", hy, 59);
    read_hist(1, hx, hy);
    check("t1_hist1_empty", hx, 0);
    model_update(109, 59);

    // 2: block moved to x 200..219, smoothed (109*10+209*6)>>4 = 146
    send_block(200, 50, 400);
    wait_publish(lat, b1);
    check_publish("t2", lat, 54, 1'b1, 146, 59, 400);
    check("t2_hist_count", hist_count, 2);
    read_hist(0, hx, hy);
    check("t2_hist0_x", hx, 146);
    check("t2_hist0_y", hy, 59);
    read_hist(1, hx, hy);
    check("t2_hist1_x", hx, 109);
    check("t2_hist1_y", hy, 59);
    model_update(209, 59);

    // 3: one pixel short of threshold
    send_block(100, 50, 399);
    wait_publish(lat, b1);
    check_publish("t3", lat, 1, 1'b0, 146, 59, 399);
    check("t3_hist_count", hist_count, 2);
    check("t3_detected_held", detected, 0);

    // 4: 12 detected frames wrap the history
    for (int k = 0; k < 12; k++) begin
      send_block(20 + 10 * k, 30, 400);
      wait_publish(lat, b1);
      model_update(29 + 10 * k, 39);
      res_x[k] = avg_x;
      res_y[k] = avg_y;
      check($sformatf("t4_f%0d_latency", k), lat, 54);
      check($sformatf("t4_f%0d_cx", k), centroid_x, avg_x);
      check($sformatf("t4_f%0d_cy", k), centroid_y, avg_y);
      @(negedge clock);
    end
    check("t4_hist_count", hist_count, 10);
    read_hist(0, hx, hy);
    check("t4_hist0_x", hx, res_x[11]);
    check("t4_hist0_y", hy, res_y[11]);
    read_hist(9, hx, hy);
    check("t4_hist9_x", hx, res_x[2]);
    check("t4_hist9_y", hy, res_y[2]);

    // 5: frame_end 10 cycles into the divide is dropped
    send_block(0, 0, 400);
    model_update(9, 9);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      clear_inputs();
      if (i >= 2 && i <= 10) begin
        pix_bus.pix_valid  = 1'b1;
        pix_bus.pix_motion = 1'b1;
        pix_bus.pix_x      = XW'(5);
        pix_bus.pix_y      = YW'(5);
        pix_bus.frame_end  = (i == 10);
      end
      #1;
      if (i == 10) check("t5_overrun", overrun, 1);
      if (i == 11) check("t5_overrun_pulse", overrun, 0);
      if (centroid_valid) begin
        lat = i;
        break;
      end
    end
    check_publish("t5", lat, 54, 1'b1, avg_x, avg_y, 400);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (centroid_valid) pulses++;
    end
    check("t5_no_second_publish", pulses, 0);
    send_block(40, 100, 400);
    wait_publish(lat, b1);
    model_update(49, 109);
    check_publish("t5b", lat, 54, 1'b1, avg_x, avg_y, 400);

    // 6: reset in the middle of the y divide, then a fresh seed
    send_block(100, 50, 400);
    for (int i = 1; i <= 35; i++) begin
      @(negedge clock);
      if (i == 1) clear_inputs();
    end
    reset = 1'b1;
    @(negedge clock);
    check("t6_busy", busy, 0);
    check("t6_cx", centroid_x, 0);
    check("t6_cy", centroid_y, 0);
    check("t6_detected", detected, 0);
    check("t6_count", motion_count, 0);
    check("t6_hist_count", hist_count, 0);
    reset = 1'b0;
    seeded = 1'b0;
    send_block(200, 50, 400);
    wait_publish(lat, b1);
    check_publish("t6b", lat, 54, 1'b1, 209, 59, 400);
    check("t6b_hist_count", hist_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
